// File: rtl/seg7_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_reader
//  Description : Readback monitor for a multiplexed active-low 7-segment bus.
//                Synchronizes anode/segment lines, waits for each key to be
//                stable, decodes the glyph to a 4-bit digit code and assembles
//                complete frames, flagging bad glyphs and multi-anode keys.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_reader #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_DIGITS-1:0]     an_n,
   input  logic [6:0]                seg_n,
   input  logic                      err_clr,
   output logic [4*NUM_DIGITS-1:0]   digits_out,
   output logic                      frame_valid,
   output logic                      frame_changed,
   output logic                      err_pattern,
   output logic                      err_anode
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam int               LOW_W   = $clog2(NUM_DIGITS + 1);
   localparam logic [3:0]       CODE_BLANK = 4'hB;

   // Active-low glyph to digit code; bit 4 of the result marks an unknown glyph.
   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'b0000001: r = {1'b0, 4'h0};
         7'b1001111: r = {1'b0, 4'h1};
         7'b0010010: r = {1'b0, 4'h2};
         7'b0000110: r = {1'b0, 4'h3};
         7'b1001100: r = {1'b0, 4'h4};
         7'b0100100: r = {1'b0, 4'h5};
         7'b0100000: r = {1'b0, 4'h6};
         7'b0001111: r = {1'b0, 4'h7};
         7'b0000000: r = {1'b0, 4'h8};
         7'b0000100: r = {1'b0, 4'h9};
         7'b1111110: r = {1'b0, 4'hA};
         7'b1111111: r = {1'b0, 4'hB};
         7'b0011100: r = {1'b0, 4'hE};
         default:    r = {1'b1, 4'hF};
      endcase
      return r;
   endfunction

   logic [1:0]                      rst_pipe;
   logic                            rst_int_n;
   logic [NUM_DIGITS-1:0]           an_meta, an_sync;
   logic [6:0]                      seg_meta, seg_sync;
   logic [CNT_W-1:0]                stab_cnt;
   logic                            cap_done;
   logic [NUM_DIGITS-1:0]           seen;
   logic [NUM_DIGITS-1:0][3:0]      digit_q;

   logic                            key_change;
   logic                            capture;
   logic [LOW_W-1:0]                low_cnt;
   logic [4:0]                      dec;
   logic [NUM_DIGITS-1:0]           wr_en;
   logic                            set_err_pattern;
   logic                            set_err_anode;
   logic                            frame_done;

   // Reset bridge: assert immediately, release aligned to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_int_n = rst_pipe[1];

   // Two-flop synchronizer on every anode and segment line.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         an_meta  <= '1;
         an_sync  <= '1;
         seg_meta <= 7'h7F;
         seg_sync <= 7'h7F;
      end else begin
         an_meta  <= an_n;
         an_sync  <= an_meta;
         seg_meta <= seg_n;
         seg_sync <= seg_meta;
      end
   end

   // Capture qualification, anode count, decode and per-digit write enables.
   // The first sync stage is the value the key takes next, so comparing the
   // two stages tells whether the key is about to change at this edge.
   always_comb begin
      key_change = ({an_meta, seg_meta} != {an_sync, seg_sync});
      capture    = (stab_cnt == CNT_MAX) && !cap_done;
      dec        = decode(seg_sync);
      low_cnt    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an_sync[i]) low_cnt = low_cnt + LOW_W'(1);
      end
      wr_en = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         wr_en[i] = capture && (low_cnt == LOW_W'(1)) && !an_sync[i];
      end
      set_err_pattern = capture && (low_cnt == LOW_W'(1)) && dec[4];
      set_err_anode   = capture && (low_cnt > LOW_W'(1));
      frame_done      = &seen;
   end

   // Stability counter with one capture per dwell.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         stab_cnt <= '0;
         cap_done <= 1'b0;
      end else if (key_change) begin
         stab_cnt <= '0;
         cap_done <= 1'b0;
      end else begin
         if (stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + CNT_W'(1);
         if (capture)             cap_done <= 1'b1;
      end
   end

   // Digit registers and coverage vector; a capture on the completion
   // cycle lands in the freshly cleared vector and counts for the next frame.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         digit_q <= {NUM_DIGITS{CODE_BLANK}};
         seen    <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_en[i]) digit_q[i] <= dec[3:0];
         end
         seen <= (frame_done ? '0 : seen) | wr_en;
      end
   end

   // Frame publication with change detection against the previous frame.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         digits_out    <= {NUM_DIGITS{CODE_BLANK}};
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
      end else begin
         frame_valid   <= frame_done;
         frame_changed <= frame_done && (digit_q != digits_out);
         if (frame_done) digits_out <= digit_q;
      end
   end

   // Sticky error flags; a new error outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         err_pattern <= 1'b0;
         err_anode   <= 1'b0;
      end else begin
         if (set_err_pattern)  err_pattern <= 1'b1;
         else if (err_clr)     err_pattern <= 1'b0;
         if (set_err_anode)    err_anode   <= 1'b1;
         else if (err_clr)     err_anode   <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_reader
//  Description : Scoreboard bench for seg7_scan_reader; expected frames are
//                queued while scanning and checked when frame_valid pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        err_clr;
   logic [15:0] digits_out;
   logic        frame_valid;
   logic        frame_changed;
   logic        err_pattern;
   logic        err_anode;

   typedef struct {
      logic [15:0] digits;
      logic        changed;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   localparam logic [6:0] BAD_A = 7'b1010101;
   localparam logic [6:0] BAD_B = 7'b0110110;
   localparam logic [6:0] BLANK = 7'b1111111;

   seg7_scan_reader #(
      .NUM_DIGITS(4), .STABLE_CYCLES(4), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .an_n(an_n), .seg_n(seg_n), .err_clr(err_clr),
      .digits_out(digits_out), .frame_valid(frame_valid),
      .frame_changed(frame_changed), .err_pattern(err_pattern),
      .err_anode(err_anode)
   );

   always #5 clk = ~clk;

   // Reference glyph table for digit codes.
   function automatic logic [6:0] glyph(input int v);
      case (v)
         0: return 7'b0000001;  1: return 7'b1001111;
         2: return 7'b0010010;  3: return 7'b0000110;
         4: return 7'b1001100;  5: return 7'b0100100;
         6: return 7'b0100000;  7: return 7'b0001111;
         8: return 7'b0000000;  9: return 7'b0000100;
         10: return 7'b1111110; 14: return 7'b0011100;
         default: return 7'b1111111;
      endcase
   endfunction

   // Frame monitor: every frame_valid pulse is checked against the queue.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && frame_valid) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_frame: digits_out=%h changed=%b, no frame expected",
                     digits_out, frame_changed);
         end else begin
            e = exp_q.pop_front();
            if (digits_out !== e.digits || frame_changed !== e.changed) begin
               fails++;
               $display("FAIL frame: got digits_out=%h changed=%b, expected %h changed=%b",
                        digits_out, frame_changed, e.digits, e.changed);
            end
         end
      end
   end

   task automatic show(input int d, input logic [6:0] pat, input int dwell);
      logic [3:0] one;
      one   = 4'b0001;
      an_n  = ~(one << d);
      seg_n = pat;
      repeat (dwell) @(negedge clk);
   endtask

   task automatic idle(input int n);
      an_n  = 4'hF;
      seg_n = BLANK;
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_frame(input logic [15:0] d, input logic ch);
      exp_t e;
      e.digits  = d;
      e.changed = ch;
      exp_q.push_back(e);
   endtask

   task automatic check_drained(input string name);
      repeat (20) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s: %0d expected frame(s) never produced, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_flags(input string name, input logic ep, input logic ea);
      tests++;
      if (err_pattern !== ep || err_anode !== ea) begin
         fails++;
         $display("FAIL %s: err_pattern=%b err_anode=%b, required %b %b",
                  name, err_pattern, err_anode, ep, ea);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; an_n = 4'hF; seg_n = BLANK; err_clr = 1'b0;
      repeat (5) @(negedge clk);
      tests++;
      if (digits_out !== 16'hBBBB || frame_valid !== 1'b0 || frame_changed !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: digits_out=%h fv=%b fc=%b, required BBBB 0 0",
                  digits_out, frame_valid, frame_changed);
      end
      check_flags("reset_flags", 1'b0, 1'b0);
      rst_n = 1'b1;
      idle(100);
      tests++;
      if (digits_out !== 16'hBBBB) begin
         fails++;
         $display("FAIL idle_digits: digits_out=%h, required BBBB", digits_out);
      end
      check_flags("idle_flags", 1'b0, 1'b0);
      check_drained("idle_no_frame");
   endtask

   task automatic test_scan();
      expect_frame(16'hA173, 1'b1);
      show(0, glyph(3), 10); show(1, glyph(7), 10);
      show(2, glyph(1), 10); show(3, glyph(10), 10);
      idle(10);
      check_drained("scan_first");
      expect_frame(16'hA173, 1'b0);
      show(0, glyph(3), 10); show(1, glyph(7), 10);
      show(2, glyph(1), 10); show(3, glyph(10), 10);
      idle(10);
      check_drained("scan_repeat");
   endtask

   task automatic test_dwell();
      expect_frame(16'h8654, 1'b1);
      show(0, glyph(4), 5); show(1, glyph(5), 5);
      show(2, glyph(6), 5); show(3, glyph(8), 5);
      idle(10);
      check_drained("dwell_plus_one");
      for (int d = 0; d < 4; d++) show(d, glyph(9), 3);
      idle(10);
      check_drained("dwell_minus_one");
      tests++;
      if (digits_out !== 16'h8654) begin
         fails++;
         $display("FAIL dwell_short_hold: digits_out=%h, required 8654", digits_out);
      end
   endtask

   task automatic test_errors();
      check_flags("err_initial", 1'b0, 1'b0);
      show(2, BAD_A, 10);
      check_flags("err_pattern_set", 1'b1, 1'b0);
      an_n = 4'b0011; seg_n = glyph(8);
      repeat (8) @(negedge clk);
      check_flags("err_anode_set", 1'b1, 1'b1);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
      check_flags("err_clear", 1'b0, 1'b0);
      show(1, BAD_B, 10);
      check_flags("err_pattern_reset", 1'b1, 1'b0);
      // err_clr lands on the capture edge of a new bad glyph.
      show(0, BAD_A, 5);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      repeat (4) @(negedge clk);
      check_flags("err_set_wins", 1'b1, 1'b0);
      expect_frame(16'h2FFF, 1'b1);
      show(3, glyph(2), 10);
      idle(10);
      check_drained("err_frame");
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
      check_flags("err_final_clear", 1'b0, 1'b0);
   endtask

   task automatic test_glitch();
      expect_frame(16'h7654, 1'b1);
      for (int d = 0; d < 4; d++) begin
         show(d, glyph(4 + d), 3);
         show(d, BAD_A, 2);
         show(d, glyph(4 + d), 10);
      end
      idle(10);
      check_drained("glitch_frame");
      check_flags("glitch_no_error", 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_frame();
      show(0, glyph(1), 10); show(1, glyph(1), 10); show(2, glyph(1), 10);
      rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if (digits_out !== 16'hBBBB || frame_valid !== 1'b0) begin
         fails++;
         $display("FAIL midreset_outputs: digits_out=%h fv=%b, required BBBB 0",
                  digits_out, frame_valid);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(10);
      expect_frame(16'h2905, 1'b1);
      show(0, glyph(5), 10); show(1, glyph(0), 10);
      show(2, glyph(9), 10); show(3, glyph(2), 10);
      idle(10);
      check_drained("midreset_frame");
      tests++;
      if (digits_out !== 16'h2905) begin
         fails++;
         $display("FAIL midreset_digits: digits_out=%h, required 2905", digits_out);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_dwell();
      test_errors();
      test_glitch();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
